// File: rtl/design_params.sv
// Shared widths and request structs for the cache request decoder, sized for
// the default configuration (32-bit addresses and data, 32-byte lines, 64 sets).
package design_params;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int BLOCK_BYTES = 32;
  localparam int SETS        = 64;
  localparam int OP_W        = 2;
  localparam int ID_W        = 3;

  localparam int BYTE_OFF_WIDTH  = $clog2(DATA_W / 8);
  localparam int BLOCK_OFF_WIDTH = $clog2(BLOCK_BYTES);
  localparam int OFFSET_WIDTH    = BLOCK_OFF_WIDTH - BYTE_OFF_WIDTH;
  localparam int INDEX_WIDTH     = $clog2(SETS);
  // A single-set cache has no index bits; keep a 1-bit field that stays 0.
  localparam int INDEX_FIELD_W   = (INDEX_WIDTH > 0) ? INDEX_WIDTH : 1;
  localparam int TAG_WIDTH       = ADDR_W - BLOCK_OFF_WIDTH - INDEX_WIDTH;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] data;
  } cache_req_t;

  typedef struct packed {
    cache_req_t                 req;
    logic [BYTE_OFF_WIDTH-1:0]  byte_off;
    logic [OFFSET_WIDTH-1:0]    offset;
    logic [INDEX_FIELD_W-1:0]   index;
    logic [TAG_WIDTH-1:0]       tag;
    logic [ADDR_W-1:0]          block_address;
  } cache_decoded_req_t;

endpackage

// File: rtl/cache_id_scoreboard.sv
// Tracks which request IDs are in flight: one busy bit per ID plus a count of
// set bits. A retire only counts when it hits a busy ID.
module cache_id_scoreboard #(
  parameter int ID_W = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   set_valid_i,
  input  logic [ID_W-1:0]        set_id_i,
  input  logic                   clr_valid_i,
  input  logic [ID_W-1:0]        clr_id_i,
  output logic [(1<<ID_W)-1:0]   busy_o,
  output logic [ID_W:0]          cnt_o
);

  localparam int N = 1 << ID_W;

  logic [N-1:0] busy_q, busy_d;
  logic [ID_W:0] cnt_q, cnt_d;
  logic          set_new, clr_hit;

  // An ID can never be set twice, so the count tops out at N.
  always_comb begin
    set_new = set_valid_i && !busy_q[set_id_i];
    clr_hit = clr_valid_i && busy_q[clr_id_i];
    busy_d  = busy_q;
    if (clr_hit) busy_d[clr_id_i] = 1'b0;
    if (set_new) busy_d[set_id_i] = 1'b1;
    cnt_d = cnt_q + {{ID_W{1'b0}}, set_new} - {{ID_W{1'b0}}, clr_hit};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/cache_req_decode.sv
// Splits cache request addresses into byte/offset/index/tag fields behind a
// 2-entry output skid buffer, blocking IDs still in flight.
// Optional alignment flag: define CACHE_DECODE_ALIGN_CHECK_EN.
module cache_req_decode
  import design_params::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int NUM_SETS      = 64,
  parameter int OP            = 2,
  parameter int REQ_ID        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  cache_req_t         in_req,
  output logic               out_valid,
  input  logic               out_ready,
  output cache_decoded_req_t out_req,
  input  logic               retire_valid,
  input  logic [REQ_ID-1:0]  retire_id,
  output logic [REQ_ID:0]    outstanding_cnt,
  output logic               out_misaligned
);

  localparam int BOW = $clog2(DATA_WIDTH / 8);
  localparam int LOW = $clog2(BLOCK_SIZE);
  localparam int IW  = $clog2(NUM_SETS);
  localparam logic [ADDRESS_WIDTH-1:0] BYTE_MASK = ADDRESS_WIDTH'((1 << BOW) - 1);
  localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK  = ADDRESS_WIDTH'((1 << (LOW - BOW)) - 1);
  localparam logic [ADDRESS_WIDTH-1:0] SET_MASK  = ADDRESS_WIDTH'(NUM_SETS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = ADDRESS_WIDTH'(BLOCK_SIZE - 1);

  logic [ADDRESS_WIDTH-1:0]  addr;
  cache_decoded_req_t        dec;
  logic [(1<<REQ_ID)-1:0]    busy;
  logic                      push, pop;
  logic                      ld0_in, ld0_shift, ld1_in;
  logic [1:0]                fill_q, fill_d;
  cache_decoded_req_t        ent0_q, ent0_d, ent1_q, ent1_d;

  assign addr = in_req.mem_address;

  always_comb begin
    dec               = '0;
    dec.req           = in_req;
    dec.req.op        = in_req.op[OP-1:0];
    dec.byte_off      = BYTE_OFF_WIDTH'(addr & BYTE_MASK);
    dec.offset        = OFFSET_WIDTH'((addr >> BOW) & OFF_MASK);
    dec.index         = INDEX_FIELD_W'((addr >> LOW) & SET_MASK);
    dec.tag           = TAG_WIDTH'(addr >> (LOW + IW));
    dec.block_address = addr & ~LINE_MASK;
  end

  cache_id_scoreboard #(
    .ID_W(REQ_ID)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_i       (rst),
    .set_valid_i (push),
    .set_id_i    (in_req.req_id),
    .clr_valid_i (retire_valid),
    .clr_id_i    (retire_id),
    .busy_o      (busy),
    .cnt_o       (outstanding_cnt)
  );

  // Readiness only looks at registered state, so a same-cycle retire cannot
  // unblock the request it is retiring.
  assign in_ready  = !rst && (fill_q != 2'd2) && !busy[in_req.req_id];
  assign push      = in_valid && in_ready;
  assign out_valid = (fill_q != 2'd0);
  assign pop       = out_valid && out_ready;

  // Entry 0 is the presented head; entry 1 holds the skid when the head stalls.
  assign ld0_in    = push && ((fill_q == 2'd0) || pop);
  assign ld0_shift = pop && !ld0_in;
  assign ld1_in    = push && (fill_q == 2'd1) && !pop;

  always_comb begin
    fill_d = fill_q + {1'b0, push} - {1'b0, pop};
    ent0_d = ent0_q;
    if (ld0_in)         ent0_d = dec;
    else if (ld0_shift) ent0_d = ent1_q;
    ent1_d = ld1_in ? dec : ent1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      fill_q <= fill_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign out_req = ent0_q;

`ifdef CACHE_DECODE_ALIGN_CHECK_EN
  logic mis_in, mis0_q, mis0_d, mis1_q, mis1_d;

  assign mis_in = (dec.byte_off != '0);

  always_comb begin
    mis0_d = mis0_q;
    if (ld0_in)         mis0_d = mis_in;
    else if (ld0_shift) mis0_d = mis1_q;
    mis1_d = ld1_in ? mis_in : mis1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mis0_q <= 1'b0;
      mis1_q <= 1'b0;
    end else begin
      mis0_q <= mis0_d;
      mis1_q <= mis1_d;
    end
  end

  assign out_misaligned = mis0_q;
`else
  assign out_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_cache_req_decode.sv
// Directed bench for cache_req_decode: stimulus pushes expected decodes into a
// queue, a negedge monitor pops and compares every delivered request.
module tb_cache_req_decode;
  import design_params::*;

`ifdef CACHE_DECODE_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  cache_req_t         in_req;
  logic               out_valid;
  logic               out_ready;
  cache_decoded_req_t out_req;
  logic               retire_valid;
  logic [2:0]         retire_id;
  logic [3:0]         outstanding_cnt;
  logic               out_misaligned;

  int errors = 0;
  int checks = 0;

  cache_decoded_req_t exp_q[$];
  logic               exp_mis_q[$];
  cache_decoded_req_t held;
  bit                 stall_prev = 1'b0;

  always #5 clk = ~clk;

  cache_req_decode dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_req          (in_req),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_req         (out_req),
    .retire_valid    (retire_valid),
    .retire_id       (retire_id),
    .outstanding_cnt (outstanding_cnt),
    .out_misaligned  (out_misaligned)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cache_decoded_req_t model(input cache_req_t r);
    cache_decoded_req_t e;
    logic [31:0] a;
    a               = r.mem_address;
    e.req           = r;
    e.byte_off      = 2'(a % 4);
    e.offset        = 3'((a / 4) % 8);
    e.index         = 6'((a / 32) % 64);
    e.tag           = 21'(a / 2048);
    e.block_address = a - (a % 32);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [2:0] id, input logic [31:0] a,
                       input bit rv, input logic [2:0] rid);
    in_valid           = v;
    in_req.op          = id[1:0];
    in_req.req_id      = id;
    in_req.mem_address = a;
    in_req.data        = {a[15:0], 13'd0, id};
    retire_valid       = rv;
    retire_id          = rid;
  endtask

  // Checks in_ready against the expected value; an expected acceptance queues
  // the expected decode for the monitor.
  task automatic accept_chk(input string name, input bit exp_rdy);
    chk(name, {63'd0, in_ready}, {63'd0, exp_rdy});
    if (exp_rdy) begin
      exp_q.push_back(model(in_req));
      exp_mis_q.push_back(ALIGN_EN && (in_req.mem_address % 4 != 0));
    end
  endtask

  task automatic chk_req_zero(input string name);
    checks++;
    if (out_req !== '0) begin
      errors++;
      $display("FAIL %s: out_req got 0x%0h, expected 0", name, out_req);
    end
  endtask

  // Monitor: compares each delivered request and holds stalled outputs.
  initial begin
    cache_decoded_req_t e;
    logic m;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (out_valid !== 1'b1 || out_req !== held) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b req=0x%0h, expected valid=1 req=0x%0h",
                     out_valid, out_req, held);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got id=%0d addr=0x%08h, expected no output",
                     out_req.req.req_id, out_req.req.mem_address);
          end else begin
            e = exp_q.pop_front();
            m = exp_mis_q.pop_front();
            if (out_req !== e || out_misaligned !== m) begin
              errors++;
              $display("FAIL out_req: got op=%0d id=%0d addr=0x%08h data=0x%08h bo=%0d off=%0d idx=%0d tag=0x%0h blk=0x%08h mis=%0b, expected op=%0d id=%0d addr=0x%08h data=0x%08h bo=%0d off=%0d idx=%0d tag=0x%0h blk=0x%08h mis=%0b",
                       out_req.req.op, out_req.req.req_id, out_req.req.mem_address, out_req.req.data,
                       out_req.byte_off, out_req.offset, out_req.index, out_req.tag,
                       out_req.block_address, out_misaligned,
                       e.req.op, e.req.req_id, e.req.mem_address, e.req.data,
                       e.byte_off, e.offset, e.index, e.tag, e.block_address, m);
            end
          end
        end
        stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
        held       = out_req;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cache_decoded_req_t h;
    rst          = 1'b1;
    out_ready    = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);

    // Reset values
    cyc(); cyc();
    neg();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_cnt", {60'd0, outstanding_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_misaligned", {63'd0, out_misaligned}, 64'd0);
    chk_req_zero("rst_out_req");
    cyc(); rst = 1'b0;
    neg();
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Field split of 0x1234_5678, hand-computed
    cyc();
    out_ready          = 1'b1;
    in_valid           = 1'b1;
    in_req.op          = 2'd2;
    in_req.req_id      = 3'd1;
    in_req.mem_address = 32'h1234_5678;
    in_req.data        = 32'hDEAD_BEEF;
    neg();
    chk("decode_in_ready", {63'd0, in_ready}, 64'd1);
    h.req           = in_req;
    h.byte_off      = 2'd0;
    h.offset        = 3'd6;
    h.index         = 6'd51;
    h.tag           = 21'h2468A;
    h.block_address = 32'h1234_5660;
    exp_q.push_back(h);
    exp_mis_q.push_back(1'b0);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg();
    chk("latency1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("cnt_after_first", {60'd0, outstanding_cnt}, 64'd1);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd1);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg();
    chk("cnt_after_retire1", {60'd0, outstanding_cnt}, 64'd0);

    // Same-ID blocking and same-cycle retire
    cyc(); drive(1'b1, 3'd2, 32'h0000_1040, 1'b0, 3'd0);
    neg(); accept_chk("id2_first", 1'b1);
    cyc(); drive(1'b1, 3'd2, 32'h0000_2080, 1'b0, 3'd0);
    neg(); accept_chk("id2_blocked", 1'b0);
    chk("id2_cnt_busy", {60'd0, outstanding_cnt}, 64'd1);
    cyc(); drive(1'b1, 3'd2, 32'h0000_2080, 1'b1, 3'd2);
    neg(); accept_chk("id2_retire_same_cycle", 1'b0);
    chk("id2_cnt_retire_cycle", {60'd0, outstanding_cnt}, 64'd1);
    cyc(); drive(1'b1, 3'd2, 32'h0000_2080, 1'b0, 3'd0);
    neg(); accept_chk("id2_after_retire", 1'b1);
    chk("id2_cnt_cleared", {60'd0, outstanding_cnt}, 64'd0);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg(); chk("id2_cnt_reaccepted", {60'd0, outstanding_cnt}, 64'd1);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd2);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);

    // Idle retire alongside an accept
    cyc(); drive(1'b1, 3'd0, 32'h0000_0300, 1'b1, 3'd5);
    neg(); accept_chk("id0_idle_retire", 1'b1);
    chk("cnt_before_idle_retire", {60'd0, outstanding_cnt}, 64'd0);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg(); chk("cnt_idle_retire", {60'd0, outstanding_cnt}, 64'd1);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg(); chk("cnt_id0_retired", {60'd0, outstanding_cnt}, 64'd0);

    // Backpressure: skid fills after two, then ordered drain
    cyc(); out_ready = 1'b0; drive(1'b1, 3'd3, 32'h0000_0100, 1'b0, 3'd0);
    neg(); accept_chk("bp_first", 1'b1);
    cyc(); drive(1'b1, 3'd4, 32'h0000_0204, 1'b0, 3'd0);
    neg(); accept_chk("bp_second", 1'b1);
    cyc(); drive(1'b1, 3'd5, 32'h0000_0308, 1'b0, 3'd0);
    neg(); accept_chk("bp_third_full", 1'b0);
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    cyc();
    neg(); accept_chk("bp_hold", 1'b0);
    chk("bp_cnt", {60'd0, outstanding_cnt}, 64'd2);
    cyc(); out_ready = 1'b1;
    neg(); accept_chk("bp_drain_edge", 1'b0);
    cyc();
    neg(); accept_chk("bp_third_accept", 1'b1);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg(); chk("bp_cnt_three", {60'd0, outstanding_cnt}, 64'd3);

    // Reset with two buffered requests and three busy IDs
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd3);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd4);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg(); chk("pre_reset_cnt", {60'd0, outstanding_cnt}, 64'd1);
    cyc(); out_ready = 1'b0; drive(1'b1, 3'd6, 32'h0000_0400, 1'b0, 3'd0);
    neg(); accept_chk("pre_reset_buf6", 1'b1);
    cyc(); drive(1'b1, 3'd7, 32'h0000_0504, 1'b0, 3'd0);
    neg(); accept_chk("pre_reset_buf7", 1'b1);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg();
    chk("pre_reset_busy3", {60'd0, outstanding_cnt}, 64'd3);
    chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    cyc(); rst = 1'b1;
    neg();
    chk("in_ready_during_reset", {63'd0, in_ready}, 64'd0);
    exp_q.delete();
    exp_mis_q.delete();
    cyc(); rst = 1'b0;
    neg();
    chk("mid_reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_reset_cnt", {60'd0, outstanding_cnt}, 64'd0);
    chk_req_zero("mid_reset_out_req");
    for (int i = 0; i < 8; i++) begin
      cyc(); in_req.req_id = 3'(i);
      neg(); chk($sformatf("post_reset_ready_id%0d", i), {63'd0, in_ready}, 64'd1);
    end
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd6);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg(); chk("retire_after_reset_ignored", {60'd0, outstanding_cnt}, 64'd0);

    // Misaligned address
    cyc(); out_ready = 1'b1; drive(1'b1, 3'd1, 32'h0000_0102, 1'b0, 3'd0);
    neg(); accept_chk("misaligned_accept", 1'b1);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg();
    chk("misaligned_flag", {63'd0, out_misaligned}, {63'd0, ALIGN_EN});
    chk("misaligned_cnt", {60'd0, outstanding_cnt}, 64'd1);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd1);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);

    // All IDs in flight: counter reaches 2^REQ_ID
    for (int i = 0; i < 8; i++) begin
      cyc(); drive(1'b1, 3'(i), 32'h0000_1000 + 32'(i) * 32'h44, 1'b0, 3'd0);
      neg(); accept_chk($sformatf("sat_accept_id%0d", i), 1'b1);
    end
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    neg(); chk("cnt_saturated", {60'd0, outstanding_cnt}, 64'd8);
    cyc(); drive(1'b1, 3'd3, 32'h0000_7777, 1'b0, 3'd0);
    neg(); accept_chk("all_busy_blocks", 1'b0);
    cyc(); drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);

    cyc(); cyc(); cyc();
    neg();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_req_decode.md
CACHE_REQ_DECODE -- requirements
Module: cache_req_decode

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32: byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: word width in bits.
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 32: line size in bytes.
REQ-004 The block SHALL have parameter NUM_SETS, default 64: set count, power of two, 1 allowed, giving INDEX_WIDTH 0.
REQ-005 The block SHALL have parameters OP, default 2, and REQ_ID, default 3: opcode width and request-ID width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-008 The block SHALL have ports in_valid and in_ready (input and output, 1 bit each) and in_req (input, raw request struct): the request-side handshake.
REQ-009 The block SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_req (output, decoded request struct): the decoded-side handshake.
REQ-010 The block SHALL have ports retire_valid (input, 1 bit) and retire_id (input, REQ_ID bits): completion of an outstanding ID.
REQ-011 The block SHALL have port outstanding_cnt, output, REQ_ID+1 bits: the number of IDs in flight.
REQ-012 The block SHALL have port out_misaligned, output, 1 bit: the alignment flag for the current out_req.

Function
REQ-013 The decode SHALL split the address into fields: byte_off = low log2(DATA_WIDTH/8) bits; offset = next OFFSET_WIDTH bits; index = next INDEX_WIDTH bits; tag = remaining upper bits.
REQ-014 block_address SHALL equal the address with its low log2(BLOCK_SIZE) bits zeroed.
REQ-015 The raw op, req_id and data fields SHALL pass through unchanged in out_req.
REQ-016 A request SHALL be accepted when in_valid && in_ready.
REQ-017 The block SHALL present an accepted request at out_valid no earlier than the cycle after acceptance, giving a minimum latency of 1.
REQ-018 The output SHALL be a 2-entry skid buffer.
REQ-019 in_ready SHALL equal !skid_full && !busy[in_req.req_id].
REQ-020 With out_ready held high, the block SHALL sustain one request per cycle.
REQ-021 out_req and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-022 Requests SHALL leave the block in acceptance order.
REQ-023 Acceptance SHALL set busy[req_id], and retire_valid SHALL clear busy[retire_id].
REQ-024 A retire in the same cycle as a blocked request with the same ID SHALL NOT unblock that request; it becomes acceptable in the next cycle.
REQ-025 A retire of an ID that is not busy SHALL be ignored, with no count change.
REQ-026 Simultaneous accept of ID a and retire of ID b, with a≠b, SHALL leave outstanding_cnt unchanged.
REQ-027 outstanding_cnt SHALL saturate at 2^REQ_ID, because no ID can be set twice.
REQ-028 With the skid buffer full, in_ready SHALL be 0 regardless of busy.

Reset
REQ-029 While rst is high at a clk edge, all outputs SHALL become 0: out_valid=0, out_req=0, out_misaligned=0, outstanding_cnt=0, in_ready=0.
REQ-030 Reset SHALL empty the skid buffer and clear every busy bit.
REQ-031 A reset mid-operation SHALL drop buffered requests, and retires arriving after reset SHALL be ignored.
REQ-032 The cycle after rst deasserts, in_ready SHALL be 1.

Configuration
REQ-033 The macro CACHE_DECODE_ALIGN_CHECK_EN SHALL control the alignment check.
REQ-034 With CACHE_DECODE_ALIGN_CHECK_EN defined, out_misaligned SHALL be registered with the request and equal (byte_off != 0); the request is still forwarded.
REQ-035 Without CACHE_DECODE_ALIGN_CHECK_EN, out_misaligned SHALL be tied to 0 and no alignment logic SHALL be built.

Structure
REQ-036 The design_params package SHALL hold INDEX_WIDTH, BYTE_OFF_WIDTH and the decoded-request struct cache_decoded_req_t, which carries the raw request plus byte_off, offset, index, tag and block_address.
REQ-037 The busy vector, counter and retire logic SHALL be the sub-module cache_id_scoreboard.

Verification
REQ-038 Default parameters, in_req.mem_address=0x1234_5678 with req_id=1, out_ready=1: the bench SHALL check out_valid 1 cycle later with byte_off=0, offset=6, index=51, tag=0x2468A and block_address=0x1234_5660.
REQ-039 ID 2 accepted, then ID 2 offered again: the bench SHALL check in_ready=0 until the cycle after retire_valid with retire_id=2, and outstanding_cnt 1→0→1.
REQ-040 out_ready=0 with 3 distinct IDs offered back-to-back: the bench SHALL check that 2 are accepted, in_ready=0, and out_req is stable; then out_ready=1 and the bench SHALL check in-order delivery.
REQ-041 rst asserted while 2 requests are buffered and 3 IDs are busy: the bench SHALL check out_valid=0 and outstanding_cnt=0 the next cycle, with all IDs acceptable.
REQ-042 With CACHE_DECODE_ALIGN_CHECK_EN defined, address 0x0000_0102: the bench SHALL check out_misaligned=1; undefined, the bench SHALL check out_misaligned=0.
REQ-043 retire_valid with an idle retire_id=5 alongside acceptance of ID 0: the bench SHALL check outstanding_cnt increments by exactly 1.
